// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
//   uart_rx_state_t : receiver FSM state encoding
//   clks_per_bit()  : clock cycles per bit period for a given clock/line rate
//   UART_DATA_BITS  : payload bits per character
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops load ResetVal
//   d     : asynchronous input
//   q     : synchronised output, two cycles of latency
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
// Received bytes are presented through a one-entry valid/ready holding register.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   rx         : serial line input, idles high, asynchronous to clk
//   data_o     : received byte, stable while valid_o is high
//   valid_o    : byte available, held until accepted with ready_i
//   ready_i    : consumer accepts data_o in any cycle where valid_o is high
//   frame_err  : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun    : one-cycle pulse, byte completed while an older one is still held
//   parity_err : one-cycle pulse, even-parity mismatch (constant 0 without UART_RX_PARITY_EN)
// Build option: UART_RX_PARITY_EN adds an even parity bit between the data and stop bits.
module uart_rx_core #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  import uart_pkg::*;

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);

  // Line synchronisation and falling-edge detection
  logic rx_s;
  logic rx_prev;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync_rx (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  // FSM and bit-timing state
  uart_rx_state_t              state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [2:0]                  bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
  logic                        par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Only a 1->0 transition starts a frame; a line stuck low stays idle.
        if (rx_prev && !rx_s) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // Start bit must still be low at mid-bit, otherwise it was a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d     = '0;
          // Even parity: line bit must equal the XOR of the data bits.
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stop-bit sample strobes
  logic stop_sample;
  logic deliver;
  logic frame_fault;
  logic parity_fault;

  always_comb begin
    stop_sample  = (state_q == STOP) && (cnt_q == BIT_END);
    deliver      = stop_sample && rx_s;
    frame_fault  = stop_sample && !rx_s;
`ifdef UART_RX_PARITY_EN
    parity_fault = stop_sample && par_bad_q;
`else
    parity_fault = 1'b0;
`endif
  end

  // Holding register and registered error pulses
  logic [7:0] data_q;
  logic       valid_q;
  logic       frame_err_q;
  logic       overrun_q;
  logic       parity_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= frame_fault;
      parity_err_q <= parity_fault;
      overrun_q    <= 1'b0;
      if (deliver) begin
        if (!valid_q || ready_i) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          // Older byte still unclaimed: keep it and drop the new one.
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: bytes expected at the output are queued
// when their frames are driven and compared when the consumer handshake occurs.
module tb_uart_rx_core;

  localparam int BIT_T  = 8680;  // one bit period at 115200 baud, 10-unit clock
  localparam int CPB    = 868;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT = 3 + CPB / 2 + 10 * CPB;
`else
  localparam int EXP_LAT = 3 + CPB / 2 + 9 * CPB;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ (100_000_000),
    .BAUD     (115200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];

  int    frame_cnt = 0;
  int    overrun_cnt = 0;
  int    parity_cnt = 0;
  int    rise_cnt = 0;
  longint t_start = 0;
  longint t_rise = 0;
  logic  valid_prev = 1'b0;
  logic  fe_prev = 1'b0;
  logic  ov_prev = 1'b0;
  logic  pe_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame; rx is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    t_start = $time;
    rx = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_T);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    #(BIT_T);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_bit;
    #(BIT_T);
  endtask

  // Output monitor: scoreboard pops on handshake, pulse counting and width checks.
  always @(negedge clk) begin
    if (valid_o && !valid_prev) begin
      rise_cnt++;
      t_rise = $time;
    end
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check_eq("sb_pending", sb.size(), 1);
      end else begin
        check_eq("rx_byte", {24'h0, data_o}, {24'h0, sb.pop_front()});
      end
    end
    if (frame_err) frame_cnt++;
    if (overrun) overrun_cnt++;
    if (parity_err) parity_cnt++;
    if (frame_err && fe_prev) check_eq("frame_err_width", {31'h0, fe_prev}, 0);
    if (overrun && ov_prev) check_eq("overrun_width", {31'h0, ov_prev}, 0);
    if (parity_err && pe_prev) check_eq("parity_err_width", {31'h0, pe_prev}, 0);
    valid_prev = valid_o;
    fe_prev    = frame_err;
    ov_prev    = overrun;
    pe_prev    = parity_err;
  end

  initial begin
    int r0;
    int f0;
    int o0;
    int p0;
    int lat;

    // Reset state
    #60;
    check_eq("rst_data", {24'h0, data_o}, 0);
    check_eq("rst_valid", {31'h0, valid_o}, 0);
    check_eq("rst_frame_err", {31'h0, frame_err}, 0);
    check_eq("rst_overrun", {31'h0, overrun}, 0);
    check_eq("rst_parity_err", {31'h0, parity_err}, 0);
    #60;
    reset = 1'b1;
    #1000;

    // 1: clean byte with consumer ready
    r0 = rise_cnt;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    #(2 * BIT_T);
    lat = int'((t_rise - t_start) / 10);
    check_eq("t1_valid_rises", rise_cnt - r0, 1);
    check_eq("t1_latency_window", {31'h0, (lat >= EXP_LAT - 2) && (lat <= EXP_LAT + 3)}, 1);
    check_eq("t1_valid_low", {31'h0, valid_o}, 0);
    check_eq("t1_sb_drained", sb.size(), 0);
    check_eq("t1_err_pulses", frame_cnt + overrun_cnt + parity_cnt, 0);

    // 2: short low glitch on an idle line
    r0 = rise_cnt;
    rx = 1'b0;
    #200;
    rx = 1'b1;
    #(3 * BIT_T);
    check_eq("t2_valid_rises", rise_cnt - r0, 0);
    check_eq("t2_err_pulses", frame_cnt + overrun_cnt + parity_cnt, 0);

    // 3: stop bit low, then line held low
    r0 = rise_cnt;
    f0 = frame_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    #50000;
    rx = 1'b1;
    #(3 * BIT_T);
    check_eq("t3_frame_err", frame_cnt - f0, 1);
    check_eq("t3_valid_rises", rise_cnt - r0, 0);
    check_eq("t3_valid_low", {31'h0, valid_o}, 0);

    // 4: overrun while consumer stalls
    @(posedge clk);
    #1 ready_i = 1'b0;
    o0 = overrun_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    #(2 * BIT_T);
    check_eq("t4_valid_held", {31'h0, valid_o}, 1);
    check_eq("t4_data_kept", {24'h0, data_o}, 32'h11);
    check_eq("t4_overrun", overrun_cnt - o0, 1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(posedge clk);
    #1 ready_i = 1'b0;
    @(negedge clk);
    check_eq("t4_valid_cleared", {31'h0, valid_o}, 0);
    check_eq("t4_sb_drained", sb.size(), 0);
    ready_i = 1'b1;

    // 5: reset in the middle of the data bits
    r0 = rise_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        #(3 * BIT_T + BIT_T / 2);
        reset = 1'b0;
        #1;
        check_eq("t5_rst_data", {24'h0, data_o}, 0);
        check_eq("t5_rst_valid", {31'h0, valid_o}, 0);
        #100;
        reset = 1'b1;
      end
    join
    #(2 * BIT_T);
    check_eq("t5_partial_dropped", rise_cnt - r0, 0);
    f0 = frame_cnt;
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    #(2 * BIT_T);
    check_eq("t5_valid_rises", rise_cnt - r0, 1);
    check_eq("t5_data", {24'h0, data_o}, 32'h5A);
    check_eq("t5_sb_drained", sb.size(), 0);
    check_eq("t5_no_frame_err", frame_cnt - f0, 0);

    // 6: parity
    p0 = parity_cnt;
    f0 = frame_cnt;
    sb.push_back(8'h07);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    #(2 * BIT_T);
    check_eq("t6_parity_err", parity_cnt - p0, 1);
`else
    send_frame(8'h07, 1'b1, 1'b0);
    #(2 * BIT_T);
    check_eq("t6_parity_never", parity_cnt, 0);
`endif
    check_eq("t6_data", {24'h0, data_o}, 32'h07);
    check_eq("t6_sb_drained", sb.size(), 0);
    check_eq("t6_no_frame_err", frame_cnt - f0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
